// File: rtl/alu_mul_seq_pkg.sv
// Shared ALU control definitions and multiply-sequencer constants.
package alu_mul_seq_pkg;

    localparam int unsigned ALU_W   = 32;
    localparam int unsigned CTRL_W  = 5;
    localparam int unsigned CNT_W   = 5;
    localparam int unsigned STARV_W = 3;

    localparam logic [CTRL_W-1:0] ALUCTRL_ADD = 5'd0;
    localparam logic [CTRL_W-1:0] ALUCTRL_SUB = 5'd1;
    localparam logic [CTRL_W-1:0] ALUCTRL_AND = 5'd2;
    localparam logic [CTRL_W-1:0] ALUCTRL_OR  = 5'd3;
    localparam logic [CTRL_W-1:0] ALUCTRL_XOR = 5'd4;

    localparam logic [STARV_W-1:0] STARV_LIMIT = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } mul_state_e;

    typedef struct packed {
        logic [CTRL_W-1:0] ctrl;
        logic [ALU_W-1:0]  rdata1;
        logic [ALU_W-1:0]  rdata2;
        logic [ALU_W-1:0]  imm;
        logic              src;
    } alu_req_t;

endpackage

// File: rtl/alu_port_mux.sv
// Two-way combinational selector for the shared ALU input port.
module alu_port_mux
    import alu_mul_seq_pkg::*;
(
    input  logic     sel_seq_i,
    input  alu_req_t pipe_req_i,
    input  alu_req_t seq_req_i,
    output alu_req_t alu_req_o
);

    always_comb begin
        alu_req_o = sel_seq_i ? seq_req_i : pipe_req_i;
    end

endmodule

// File: rtl/alu_mul_seq.sv
// Shift-and-add multiplier that borrows the pipeline ALU in idle/stalled cycles,
// forcing a one-cycle pipeline stall when the pipeline keeps the ALU too long.
module alu_mul_seq
    import alu_mul_seq_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pipe_valid,
    input  logic [CTRL_W-1:0] pipe_ctrl,
    input  logic [ALU_W-1:0]  pipe_a,
    input  logic [ALU_W-1:0]  pipe_b,
    input  logic [ALU_W-1:0]  pipe_imm,
    input  logic              pipe_src,
    output logic              pipe_stall,
    input  logic              mul_valid,
    output logic              mul_ready,
    input  logic [ALU_W-1:0]  mul_a,
    input  logic [ALU_W-1:0]  mul_b,
    output logic              mul_done,
    output logic [ALU_W-1:0]  mul_result,
    output logic              busy,
    output logic [ALU_W-1:0]  alu_rdata1,
    output logic [ALU_W-1:0]  alu_rdata2,
    output logic [ALU_W-1:0]  alu_imm,
    output logic              alu_src,
    output logic [CTRL_W-1:0] alu_ctrl,
    input  logic [ALU_W-1:0]  alu_result
);

    mul_state_e         state_q, state_d;
    logic [ALU_W-1:0]   acc_q, acc_d;
    logic [ALU_W-1:0]   mcand_q, mcand_d;
    logic [ALU_W-1:0]   mplier_q, mplier_d;
    logic [ALU_W-1:0]   result_q, result_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [STARV_W-1:0] starv_q, starv_d;
    logic               stall_q, stall_d;

    logic               pipe_own_c;
    logic               slot_c;
    logic               add_c;
    logic [ALU_W-1:0]   mplier_sh_c;
    alu_req_t           pipe_req_c, seq_req_c, alu_req_c;

    // Pipeline owns the ALU unless it is idle or held by our stall.
    always_comb begin
        pipe_own_c  = pipe_valid && !stall_q;
        slot_c      = (state_q == ST_RUN) && !pipe_own_c;
        add_c       = slot_c && mplier_q[0];
        mplier_sh_c = mplier_q >> 1;

        pipe_req_c = '{ctrl: pipe_ctrl, rdata1: pipe_a, rdata2: pipe_b,
                       imm: pipe_imm, src: pipe_src};

        seq_req_c        = '0;
        seq_req_c.ctrl   = ALUCTRL_ADD;
        if (add_c) begin
            seq_req_c.rdata1 = acc_q;
            seq_req_c.rdata2 = mcand_q;
        end
    end

    alu_port_mux u_alu_port_mux (
        .sel_seq_i  (!pipe_own_c),
        .pipe_req_i (pipe_req_c),
        .seq_req_i  (seq_req_c),
        .alu_req_o  (alu_req_c)
    );

    assign alu_ctrl   = alu_req_c.ctrl;
    assign alu_rdata1 = alu_req_c.rdata1;
    assign alu_rdata2 = alu_req_c.rdata2;
    assign alu_imm    = alu_req_c.imm;
    assign alu_src    = alu_req_c.src;

    // Next-state and datapath updates.
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        result_d = result_q;
        cnt_d    = cnt_q;
        starv_d  = starv_q;
        stall_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (mul_valid) begin
                    mcand_d  = mul_a;
                    mplier_d = mul_b;
                    acc_d    = '0;
                    cnt_d    = '0;
                    starv_d  = '0;
                    if (mul_b == '0) begin
                        state_d  = ST_DONE;
                        result_d = '0;
                    end else begin
                        state_d  = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (slot_c) begin
                    if (mplier_q[0]) begin
                        acc_d = alu_result;
                    end
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_sh_c;
                    cnt_d    = cnt_q + CNT_W'(1);
                    starv_d  = '0;
                    if ((mplier_sh_c == '0) || (cnt_q == {CNT_W{1'b1}})) begin
                        state_d  = ST_DONE;
                        result_d = acc_d;
                    end
                end else begin
                    starv_d = starv_q + STARV_W'(1);
                    stall_d = (starv_d == STARV_LIMIT);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                starv_d = '0;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            result_q <= '0;
            cnt_q    <= '0;
            starv_q  <= '0;
            stall_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            result_q <= result_d;
            cnt_q    <= cnt_d;
            starv_q  <= starv_d;
            stall_q  <= stall_d;
        end
    end

    assign mul_ready  = (state_q == ST_IDLE);
    assign busy       = (state_q != ST_IDLE);
    assign mul_done   = (state_q == ST_DONE);
    assign mul_result = result_q;
    assign pipe_stall = stall_q;

endmodule
